// File: rtl/symbol_pkg.sv
// Shared definitions for the receive-side symbol path: symbol width,
// K28.5 comma encodings in both running disparities, the aligner
// state encoding and a small phase-counter helper.
package symbol_pkg;

    localparam int SYM_W = 10;

    // K28.5 as a 10-bit value with bit 0 = 'a', the first bit on the line.
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

    // Phase counter runs 0..PHASE_LAST; the edge with cnt == PHASE_LAST
    // samples the last bit of a symbol once alignment is known.
    localparam logic [3:0] PHASE_LAST = 4'd9;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_t;

    // Next value of the free-running symbol phase counter.
    function automatic logic [3:0] phase_next(input logic [3:0] phase);
        return (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
    endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 comma detector. Accepts either running disparity.
// Kept standalone so the elastic-buffer SKP logic can reuse it.
module comma_detect
    import symbol_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             match
);

    assign match = (sym == K28_5_RDN) || (sym == K28_5_RDP);

endmodule

// File: rtl/symbol_aligner.sv
// Serial-to-symbol aligner. Shifts in one bit per clock (LSB of each
// symbol first), hunts for K28.5 commas to find the 10-bit boundary,
// confirms it with further aligned commas and then holds lock until
// ERR_MAX consecutive off-boundary commas are seen.
//
// Output handshake: VALID is a one-cycle strobe with no back-pressure.
// OP and K_DET are meaningful only in the cycle VALID is high; OP holds
// its last value otherwise and K_DET is low. There is no ready signal,
// so a consumer must take the symbol in the strobe cycle.
module symbol_aligner
    import symbol_pkg::*;
#(
    parameter int LOCK_COMMAS = 2,
    parameter int ERR_MAX     = 3
) (
    input  logic             CLOCK,
    input  logic             RESET_L,
    input  logic             IS,
    output logic [SYM_W-1:0] OP,
    output logic             VALID,
    output logic             K_DET,
    output logic             LOCKED,
    output logic [1:0]       dbg_state
);

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_COMMAS);
    localparam logic [7:0] ERR_TGT  = 8'(ERR_MAX);

    align_state_t     state;
    align_state_t     state_nxt;
    logic [SYM_W-1:0] sr;
    logic [SYM_W-1:0] nsr;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [7:0]       confirm;
    logic [7:0]       confirm_nxt;
    logic [7:0]       err;
    logic [7:0]       err_nxt;
    logic             comma;
    logic             boundary;
    logic             emit;

    // All decisions look at the window including the bit sampled this
    // edge, so a symbol is emitted on the edge that takes its 10th bit.
    assign nsr = {IS, sr[SYM_W-1:1]};

    comma_detect u_comma_detect (
        .sym   (nsr),
        .match (comma)
    );

    // Boundary edges only exist once a phase has been chosen.
    assign boundary = (state != ST_HUNT) && (cnt == PHASE_LAST);

    assign dbg_state = state;

    // Next-state, counter and emission decisions.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = phase_next(cnt);
        confirm_nxt = confirm;
        err_nxt     = err;
        emit        = 1'b0;
        case (state)
            ST_HUNT: begin
                // Any comma fixes the phase: this edge is the boundary.
                if (comma) begin
                    cnt_nxt     = 4'd0;
                    confirm_nxt = 8'd1;
                    err_nxt     = 8'd0;
                    emit        = 1'b1;
                    state_nxt   = (LOCK_TGT <= 8'd1) ? ST_LOCKED : ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (comma) begin
                        confirm_nxt = confirm + 8'd1;
                        if (confirm_nxt >= LOCK_TGT) begin
                            state_nxt = ST_LOCKED;
                            err_nxt   = 8'd0;
                        end
                    end
                end else if (comma) begin
                    // Lock not yet trusted: follow the comma to its phase.
                    cnt_nxt     = 4'd0;
                    confirm_nxt = 8'd1;
                    emit        = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (comma) begin
                        err_nxt = 8'd0;
                    end
                end else if (comma) begin
                    // Misplaced comma: counted, never used to realign here.
                    // The comma that trips the limit is dropped; hunting
                    // resumes from the following edge.
                    if (err + 8'd1 >= ERR_TGT) begin
                        state_nxt   = ST_HUNT;
                        err_nxt     = 8'd0;
                        confirm_nxt = 8'd0;
                    end else begin
                        err_nxt = err + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    // State, shift register, counters and registered outputs.
    always_ff @(posedge CLOCK or negedge RESET_L) begin
        if (!RESET_L) begin
            state   <= ST_HUNT;
            sr      <= '0;
            cnt     <= 4'd0;
            confirm <= 8'd0;
            err     <= 8'd0;
            OP      <= '0;
            VALID   <= 1'b0;
            K_DET   <= 1'b0;
            LOCKED  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= nsr;
            cnt     <= cnt_nxt;
            confirm <= confirm_nxt;
            err     <= err_nxt;
            VALID   <= emit;
            K_DET   <= emit && comma;
            LOCKED  <= (state_nxt == ST_LOCKED);
            if (emit) begin
                OP <= nsr;
            end
        end
    end

endmodule

// File: tb/tb_symbol_aligner.sv
// Directed bench for symbol_aligner: acquisition, confirmation, loss of
// lock on misplaced commas, error-counter clearing, async reset and
// realignment while confirming. Expected symbols go into a queue that a
// negedge monitor drains whenever VALID strobes.
module tb_symbol_aligner;
    import symbol_pkg::*;

    logic             CLOCK;
    logic             RESET_L;
    logic             IS;
    logic [SYM_W-1:0] OP;
    logic             VALID;
    logic             K_DET;
    logic             LOCKED;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected strobes: {k_det, op}.
    logic [10:0] exp_q[$];

    int bit_no    = 0;
    int last_vpos = -1;
    int vcount    = 0;
    int t0;
    int pr;
    int vsnap;

    // Clock and reset.
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    symbol_aligner #(
        .LOCK_COMMAS (2),
        .ERR_MAX     (3)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET_L   (RESET_L),
        .IS        (IS),
        .OP        (OP),
        .VALID     (VALID),
        .K_DET     (K_DET),
        .LOCKED    (LOCKED),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one line bit; sample outputs 1 time unit after the edge.
    task automatic send_bit(input logic b);
        IS = b;
        @(posedge CLOCK);
        #1;
        if (VALID === 1'b1) begin
            last_vpos = bit_no;
            vcount++;
        end
        bit_no++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) begin
            send_bit(s[i]);
        end
    endtask

    task automatic expect_sym(input logic k, input logic [9:0] v);
        exp_q.push_back({k, v});
    endtask

    // Scoreboard: every strobe must match the oldest expected symbol.
    always @(negedge CLOCK) begin
        logic [10:0] e;
        if (RESET_L === 1'b1 && VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("valid_without_expectation", 32'(VALID), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sym_op", 32'(OP), 32'(e[9:0]));
                check("sym_k", 32'(K_DET), 32'(e[10]));
            end
        end
    end

    initial begin
        RESET_L = 1'b0;
        IS      = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_op", 32'(OP), 32'd0);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_kdet", 32'(K_DET), 32'd0);
        check("rst_locked", 32'(LOCKED), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_HUNT));
        RESET_L = 1'b1;

        // Idle line: no strobes, no lock.
        repeat (40) send_bit(1'b0);
        check("idle_vcount", 32'(vcount), 32'd0);
        check("idle_locked", 32'(LOCKED), 32'd0);
        check("idle_op", 32'(OP), 32'd0);

        // Junk bits, then acquire on 0x17C, data 0x2AA, confirm on 0x283.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        t0 = bit_no;
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("acq_pos", 32'(last_vpos), 32'(t0 + 9));
        check("acq_state", 32'(dbg_state), 32'(ST_CONFIRM));
        check("acq_locked", 32'(LOCKED), 32'd0);
        expect_sym(1'b0, 10'h2AA);
        send_sym(10'h2AA);
        check("data_pos", 32'(last_vpos), 32'(t0 + 19));
        check("data_locked", 32'(LOCKED), 32'd0);
        expect_sym(1'b1, 10'h283);
        send_sym(10'h283);
        check("conf_pos", 32'(last_vpos), 32'(t0 + 29));
        check("conf_kdet", 32'(K_DET), 32'd1);
        check("conf_locked", 32'(LOCKED), 32'd1);
        check("conf_state", 32'(dbg_state), 32'(ST_LOCKED));

        // Locked traffic, then one extra bit: three off-boundary commas.
        // Each boundary then holds {0x17C[8:0], 0} = 0x2F8.
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        expect_sym(1'b0, 10'h2AA);
        send_sym(10'h2AA);
        check("lk_locked", 32'(LOCKED), 32'd1);
        send_bit(1'b0);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("err1_locked", 32'(LOCKED), 32'd1);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("err2_locked", 32'(LOCKED), 32'd1);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("err3_locked", 32'(LOCKED), 32'd0);
        check("err3_state", 32'(dbg_state), 32'(ST_HUNT));

        // Reacquire on the next comma, lock on the one after.
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("reacq_pos", 32'(last_vpos), 32'(bit_no - 1));
        check("reacq_state", 32'(dbg_state), 32'(ST_CONFIRM));
        check("reacq_locked", 32'(LOCKED), 32'd0);
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("relock_locked", 32'(LOCKED), 32'd1);

        // Two misplaced commas, one aligned, two misplaced: lock holds.
        send_bit(1'b0);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("clr_a_locked", 32'(LOCKED), 32'd1);
        expect_sym(1'b0, 10'h000);
        repeat (9) send_bit(1'b0);
        check("clr_pad_pos", 32'(last_vpos), 32'(bit_no - 1));
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("clr_aligned_locked", 32'(LOCKED), 32'd1);
        send_bit(1'b0);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("clr_b1_locked", 32'(LOCKED), 32'd1);
        expect_sym(1'b0, 10'h2F8);
        send_sym(10'h17C);
        check("clr_b2_locked", 32'(LOCKED), 32'd1);
        check("clr_b2_state", 32'(dbg_state), 32'(ST_LOCKED));

        // Back on phase, then reset five bits into a symbol.
        expect_sym(1'b0, 10'h000);
        repeat (9) send_bit(1'b0);
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("pre_rst_locked", 32'(LOCKED), 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        RESET_L = 1'b0;
        #1;
        check("mid_rst_op", 32'(OP), 32'd0);
        check("mid_rst_valid", 32'(VALID), 32'd0);
        check("mid_rst_kdet", 32'(K_DET), 32'd0);
        check("mid_rst_locked", 32'(LOCKED), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_HUNT));
        IS = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET_L = 1'b1;
        vsnap = vcount;
        repeat (12) send_bit(1'b0);
        check("post_rst_quiet", 32'(vcount), 32'(vsnap));
        check("post_rst_locked", 32'(LOCKED), 32'd0);
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("post_rst_acq_pos", 32'(last_vpos), 32'(bit_no - 1));
        check("post_rst_state", 32'(dbg_state), 32'(ST_CONFIRM));

        // While confirming, a comma four bits late moves the phase.
        // Old boundary sees 4 zeros then 0x17C[5:0]: 0x3C0.
        expect_sym(1'b0, 10'h3C0);
        expect_sym(1'b1, 10'h17C);
        repeat (4) send_bit(1'b0);
        send_sym(10'h17C);
        pr = last_vpos;
        check("shift_pos", 32'(pr), 32'(bit_no - 1));
        check("shift_state", 32'(dbg_state), 32'(ST_CONFIRM));
        check("shift_locked", 32'(LOCKED), 32'd0);
        expect_sym(1'b1, 10'h17C);
        send_sym(10'h17C);
        check("shift_spacing", 32'(last_vpos), 32'(pr + 10));
        check("shift_lock", 32'(LOCKED), 32'd1);

        repeat (3) send_bit(1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
